// File: rtl/bpf_stage1.sv
// Ingress stage of the bad-packet filter: registers the MAC RX stream into the
// data FIFO, garbages oversize tails, closes overflowed packets with a GARBAGE
// TLAST beat and emits one status byte per packet.
//
// state | meaning
// SYNC  | discarding until a TLAST beat (after reset, possibly mid-packet)
// IDLE  | between packets, next beat starts a packet
// PASS  | inside a packet, beats are forwarded
// DROP  | packet overflowed, discarding until its TLAST
// FLUSH | waiting to write the GARBAGE TLAST beat that closes a dropped packet
module bpf_stage1 #(
  parameter int DATA_WIDTH = 512,
  parameter int MAX_CYCLES = 150,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_WIDTH-1:0]   AXIS_RX_TDATA,
  input  logic [DATA_WIDTH/8-1:0] AXIS_RX_TKEEP,
  input  logic                    AXIS_RX_TVALID,
  input  logic                    AXIS_RX_TLAST,
  input  logic                    AXIS_RX_TUSER,
  output logic [DATA_WIDTH-1:0]   AXIS_TX_TDATA,
  output logic [DATA_WIDTH/8-1:0] AXIS_TX_TKEEP,
  output logic                    AXIS_TX_TVALID,
  output logic                    AXIS_TX_TLAST,
  output logic                    AXIS_TX_TUSER,
  input  logic                    AXIS_TX_TREADY,
  output logic [7:0]              AXIS_PS_TDATA,
  output logic                    AXIS_PS_TVALID,
  input  logic                    AXIS_PS_TREADY,
  output logic [CNT_WIDTH-1:0]    good_count,
  output logic [CNT_WIDTH-1:0]    bad_count,
  output logic                    ps_overflow
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int NW = $clog2(MAX_CYCLES + 2);
  localparam logic [DATA_WIDTH-1:0] GARBAGE = {KW{8'hFE}};

  typedef enum logic [2:0] {SYNC, IDLE, PASS, DROP, FLUSH} state_t;

  state_t        state, state_d;
  logic [NW-1:0] n, n_d;
  logic          f_fcs, f_big, f_ovf, f_fcs_d, f_big_d, f_ovf_d;
  logic          cur_fcs, cur_big, cur_ovf;
  logic          pend, pend_last, pend_fcs, pend_d, pend_last_d, pend_fcs_d;
  logic          tx_load, tx_flush, issue;
  logic          can_acc, big_beat;
  logic          new_last_beat, nx_pend, nx_last, nx_fcs;
  logic [7:0]    status;

  assign can_acc  = ~AXIS_TX_TVALID | AXIS_TX_TREADY;
  assign big_beat = (n > NW'(MAX_CYCLES));

  // A packet that starts while FLUSH is still waiting is tracked here so it can
  // be dropped and marked overflowed once the flush beat goes out.
  assign new_last_beat = AXIS_RX_TVALID & AXIS_RX_TLAST & ~pend_last;
  assign nx_pend       = pend | AXIS_RX_TVALID;
  assign nx_last       = pend_last | new_last_beat;
  assign nx_fcs        = new_last_beat ? AXIS_RX_TUSER : pend_fcs;

  assign status = {4'b0, cur_ovf, cur_big, cur_fcs, cur_ovf | cur_big | cur_fcs};

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= SYNC;
    else         state <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state;
    case (state)
      SYNC:  if (AXIS_RX_TVALID && AXIS_RX_TLAST) state_d = IDLE;
      IDLE, PASS: begin
        if (AXIS_RX_TVALID) begin
          if (can_acc) state_d = AXIS_RX_TLAST ? IDLE : PASS;
          else         state_d = AXIS_RX_TLAST ? FLUSH : DROP;
        end
      end
      DROP:  if (AXIS_RX_TVALID && AXIS_RX_TLAST) state_d = FLUSH;
      FLUSH: begin
        if (can_acc) begin
          if (nx_pend) state_d = nx_last ? FLUSH : DROP;
          else         state_d = IDLE;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // Per-state actions: TX writes, status issue, flag and beat-count updates
  always_comb begin
    tx_load     = 1'b0;
    tx_flush    = 1'b0;
    issue       = 1'b0;
    cur_fcs     = f_fcs;
    cur_big     = f_big;
    cur_ovf     = f_ovf;
    f_fcs_d     = f_fcs;
    f_big_d     = f_big;
    f_ovf_d     = f_ovf;
    n_d         = n;
    pend_d      = pend;
    pend_last_d = pend_last;
    pend_fcs_d  = pend_fcs;
    case (state)
      IDLE, PASS: begin
        if (AXIS_RX_TVALID) begin
          if (can_acc) begin
            tx_load = 1'b1;
            cur_big = f_big | big_beat;
            if (AXIS_RX_TLAST) begin
              cur_fcs = AXIS_RX_TUSER;
              issue   = 1'b1;
              f_fcs_d = 1'b0;
              f_big_d = 1'b0;
              f_ovf_d = 1'b0;
              n_d     = NW'(1);
            end else begin
              f_big_d = cur_big;
              if (n <= NW'(MAX_CYCLES)) n_d = n + NW'(1);
            end
          end else begin
            f_ovf_d = 1'b1;
            if (AXIS_RX_TLAST) f_fcs_d = AXIS_RX_TUSER;
          end
        end
      end
      DROP: if (AXIS_RX_TVALID && AXIS_RX_TLAST) f_fcs_d = AXIS_RX_TUSER;
      FLUSH: begin
        pend_d      = nx_pend;
        pend_last_d = nx_last;
        pend_fcs_d  = nx_fcs;
        if (can_acc) begin
          tx_flush    = 1'b1;
          issue       = 1'b1;
          n_d         = NW'(1);
          pend_d      = 1'b0;
          pend_last_d = 1'b0;
          pend_fcs_d  = 1'b0;
          f_ovf_d     = nx_pend;
          f_big_d     = 1'b0;
          f_fcs_d     = nx_pend & nx_last & nx_fcs;
        end
      end
      default: ;
    endcase
  end

  // Packet bookkeeping registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      n         <= NW'(1);
      f_fcs     <= 1'b0;
      f_big     <= 1'b0;
      f_ovf     <= 1'b0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      pend_fcs  <= 1'b0;
    end else begin
      n         <= n_d;
      f_fcs     <= f_fcs_d;
      f_big     <= f_big_d;
      f_ovf     <= f_ovf_d;
      pend      <= pend_d;
      pend_last <= pend_last_d;
      pend_fcs  <= pend_fcs_d;
    end
  end

  // Single TX output register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      AXIS_TX_TDATA  <= '0;
      AXIS_TX_TKEEP  <= '0;
      AXIS_TX_TVALID <= 1'b0;
      AXIS_TX_TLAST  <= 1'b0;
      AXIS_TX_TUSER  <= 1'b0;
    end else if (tx_load) begin
      AXIS_TX_TDATA  <= cur_big ? GARBAGE : AXIS_RX_TDATA;
      AXIS_TX_TKEEP  <= AXIS_RX_TKEEP;
      AXIS_TX_TVALID <= 1'b1;
      AXIS_TX_TLAST  <= AXIS_RX_TLAST;
      AXIS_TX_TUSER  <= AXIS_RX_TLAST & status[0];
    end else if (tx_flush) begin
      AXIS_TX_TDATA  <= GARBAGE;
      AXIS_TX_TKEEP  <= '1;
      AXIS_TX_TVALID <= 1'b1;
      AXIS_TX_TLAST  <= 1'b1;
      AXIS_TX_TUSER  <= status[0];
    end else if (AXIS_TX_TREADY) begin
      AXIS_TX_TVALID <= 1'b0;
    end
  end

  // Status register and statistics; a still-pending byte makes the new one lost
  always_ff @(posedge clk) begin
    if (!resetn) begin
      AXIS_PS_TDATA  <= 8'h00;
      AXIS_PS_TVALID <= 1'b0;
      ps_overflow    <= 1'b0;
      good_count     <= '0;
      bad_count      <= '0;
    end else begin
      if (issue) begin
        if (AXIS_PS_TVALID && !AXIS_PS_TREADY) begin
          ps_overflow <= 1'b1;
        end else begin
          AXIS_PS_TDATA  <= status;
          AXIS_PS_TVALID <= 1'b1;
        end
        if (status[0]) bad_count  <= bad_count + CNT_WIDTH'(1);
        else           good_count <= good_count + CNT_WIDTH'(1);
      end else if (AXIS_PS_TREADY) begin
        AXIS_PS_TVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bpf_stage1.sv
// Bench for bpf_stage1: packet table, multi-cycle corner sequences and random
// packets, all checked against a packet-level expectation model.
module tb_bpf_stage1;
  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int MAXC = 4;
  localparam int CW = 32;
  localparam logic [DW-1:0] GARB = {KW{8'hFE}};

  typedef struct packed {
    logic          last;
    logic          user;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    int         len;
    bit         tuser;
    logic [7:0] ps;
  } vec_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] rx_tdata;
  logic [KW-1:0] rx_tkeep;
  logic          rx_tvalid, rx_tlast, rx_tuser;
  logic [DW-1:0] tx_tdata;
  logic [KW-1:0] tx_tkeep;
  logic          tx_tvalid, tx_tlast, tx_tuser, tx_tready;
  logic [7:0]    ps_tdata;
  logic          ps_tvalid, ps_tready;
  logic [CW-1:0] good_count, bad_count;
  logic          ps_overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_good = 0;
  int exp_bad  = 0;
  bit exp_ovf  = 0;
  bit mon_en   = 0;

  beat_t      exp_tx[$];
  beat_t      got_tx[$];
  logic [7:0] exp_ps[$];
  logic [7:0] got_ps[$];
  beat_t      mb;
  vec_t       vt[7];

  always #5 clk = ~clk;

  bpf_stage1 #(.DATA_WIDTH(DW), .MAX_CYCLES(MAXC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn),
    .AXIS_RX_TDATA(rx_tdata), .AXIS_RX_TKEEP(rx_tkeep), .AXIS_RX_TVALID(rx_tvalid),
    .AXIS_RX_TLAST(rx_tlast), .AXIS_RX_TUSER(rx_tuser),
    .AXIS_TX_TDATA(tx_tdata), .AXIS_TX_TKEEP(tx_tkeep), .AXIS_TX_TVALID(tx_tvalid),
    .AXIS_TX_TLAST(tx_tlast), .AXIS_TX_TUSER(tx_tuser), .AXIS_TX_TREADY(tx_tready),
    .AXIS_PS_TDATA(ps_tdata), .AXIS_PS_TVALID(ps_tvalid), .AXIS_PS_TREADY(ps_tready),
    .good_count(good_count), .bad_count(bad_count), .ps_overflow(ps_overflow)
  );

  // Record every completed handshake, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_tvalid && tx_tready) begin
        mb.last = tx_tlast;
        mb.user = tx_tuser;
        mb.keep = tx_tkeep;
        mb.data = tx_tdata;
        got_tx.push_back(mb);
      end
      if (ps_tvalid && ps_tready) got_ps.push_back(ps_tdata);
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [KW-1:0] k,
                       input logic l, input logic u);
    rx_tvalid = v;
    rx_tdata  = d;
    rx_tkeep  = k;
    rx_tlast  = l;
    rx_tuser  = u;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++)
      drive(1'b0, {$urandom, $urandom}, KW'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic push_ps(input logic [7:0] ps);
    exp_ps.push_back(ps);
    if (ps[0]) exp_bad++;
    else       exp_good++;
  endtask

  // Send one packet; expected beats follow the oversize rule, status comes from ps
  task automatic send_pkt(input int len, input bit tuser, input int gap_max,
                          input bit lat, input logic [7:0] ps);
    beat_t         e;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    for (int i = 1; i <= len; i++) begin
      d = {$urandom, $urandom};
      k = KW'($urandom);
      e.last = (i == len);
      e.user = (i == len) ? ps[0] : 1'b0;
      e.keep = k;
      e.data = (i > MAXC) ? GARB : d;
      exp_tx.push_back(e);
      drive(1'b1, d, k, i == len, (i == len) ? tuser : 1'($urandom));
      if (lat) check("latency_beat", {63'd0, tx_tvalid, tx_tdata}, {63'd0, 1'b1, e.data});
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
    push_ps(ps);
  endtask

  task automatic compare_all(input string tag);
    beat_t e;
    beat_t g;
    while (exp_tx.size() > 0) begin
      e = exp_tx.pop_front();
      if (got_tx.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s tx_beat actual=none required=%0h", tag, e);
      end else begin
        g = got_tx.pop_front();
        check({tag, " tx_beat"}, 128'(g), 128'(e));
      end
    end
    check({tag, " tx_extra"}, 128'(got_tx.size()), 128'd0);
    while (exp_ps.size() > 0) begin
      if (got_ps.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s ps_byte actual=none required=%0h", tag, exp_ps.pop_front());
      end else begin
        check({tag, " ps_byte"}, 128'(got_ps.pop_front()), 128'(exp_ps.pop_front()));
      end
    end
    check({tag, " ps_extra"}, 128'(got_ps.size()), 128'd0);
    check({tag, " good_count"}, 128'(good_count), 128'(exp_good));
    check({tag, " bad_count"}, 128'(bad_count), 128'(exp_bad));
    check({tag, " ps_overflow"}, 128'(ps_overflow), 128'(exp_ovf));
    got_tx.delete();
    got_ps.delete();
  endtask

  // Reset, then send one TLAST beat that SYNC must swallow
  task automatic reset_sync();
    resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
    exp_good = 0;
    exp_bad  = 0;
    exp_ovf  = 0;
    drive(1'b1, {$urandom, $urandom}, '1, 1'b1, 1'b0);
    idle(2);
  endtask

  initial begin
    beat_t e;
    int    len;
    bit    tu;
    bit    big;

    vt[0] = '{3, 1'b0, 8'h00};
    vt[1] = '{2, 1'b1, 8'h03};
    vt[2] = '{6, 1'b0, 8'h05};
    vt[3] = '{4, 1'b0, 8'h00};
    vt[4] = '{5, 1'b0, 8'h05};
    vt[5] = '{1, 1'b1, 8'h03};
    vt[6] = '{5, 1'b1, 8'h07};

    resetn    = 1'b0;
    tx_tready = 1'b1;
    ps_tready = 1'b1;
    rx_tvalid = 1'b0;
    rx_tdata  = '0;
    rx_tkeep  = '0;
    rx_tlast  = 1'b0;
    rx_tuser  = 1'b0;

    // Reset state, with RX activity during reset
    for (int i = 0; i < 3; i++) drive(1'b1, {$urandom, $urandom}, '1, 1'($urandom), 1'b1);
    check("reset tx_tvalid", 128'(tx_tvalid), 128'd0);
    check("reset ps_tvalid", 128'(ps_tvalid), 128'd0);
    check("reset ps_tdata", 128'(ps_tdata), 128'd0);
    check("reset counts", {64'd0, good_count, bad_count}, 128'd0);
    check("reset ps_overflow", 128'(ps_overflow), 128'd0);
    resetn = 1'b1;
    mon_en = 1'b1;
    drive(1'b1, {$urandom, $urandom}, '1, 1'b1, 1'b0);
    idle(2);
    compare_all("sync");

    // Table of single packets, full throughput, per-beat latency checked
    for (int v = 0; v < 7; v++) begin
      send_pkt(vt[v].len, vt[v].tuser, 0, 1'b1, vt[v].ps);
      idle(2);
      compare_all($sformatf("vec%0d", v));
    end

    // TX backpressure mid-packet, then a packet arriving during the flush
    drive(1'b1, 64'h1111, 8'hFF, 1'b0, 1'b0);
    exp_tx.push_back('{1'b0, 1'b0, 8'hFF, 64'h1111});
    drive(1'b1, 64'h2222, 8'h0F, 1'b0, 1'b0);
    exp_tx.push_back('{1'b0, 1'b0, 8'h0F, 64'h2222});
    tx_tready = 1'b0;
    drive(1'b1, 64'h3333, 8'hFF, 1'b0, 1'b0);
    check("hold tx_tdata", 128'(tx_tdata), 128'h2222);
    drive(1'b1, 64'h4444, 8'hFF, 1'b0, 1'b0);
    check("hold tx_tvalid_data", {63'd0, tx_tvalid, tx_tdata}, {63'd0, 1'b1, 64'h2222});
    tx_tready = 1'b1;
    drive(1'b1, 64'h5555, 8'hFF, 1'b1, 1'b0);
    drive(1'b1, 64'h6666, 8'hFF, 1'b0, 1'b0);
    drive(1'b1, 64'h7777, 8'hFF, 1'b1, 1'b1);
    idle(4);
    exp_tx.push_back('{1'b1, 1'b1, '1, GARB});
    exp_tx.push_back('{1'b1, 1'b1, '1, GARB});
    push_ps(8'h09);
    push_ps(8'h0B);
    compare_all("ovf_flush");

    // Reset in the middle of a packet
    mon_en = 1'b0;
    drive(1'b1, 64'hA1, 8'hFF, 1'b0, 1'b0);
    drive(1'b1, 64'hA2, 8'hFF, 1'b0, 1'b0);
    resetn = 1'b0;
    idle(2);
    check("midrst tx_tvalid", 128'(tx_tvalid), 128'd0);
    check("midrst counts", {64'd0, good_count, bad_count}, 128'd0);
    resetn = 1'b1;
    exp_good = 0;
    exp_bad  = 0;
    got_tx.delete();
    got_ps.delete();
    mon_en = 1'b1;
    drive(1'b1, 64'hA3, 8'hFF, 1'b0, 1'b0);
    drive(1'b1, 64'hA4, 8'hFF, 1'b1, 1'b1);
    send_pkt(3, 1'b0, 0, 1'b0, 8'h00);
    idle(2);
    compare_all("midrst");

    // Random packets with gaps; expectations from packet length and FCS flag
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 7);
      tu  = 1'($urandom);
      big = (len > MAXC);
      send_pkt(len, tu, 2, 1'b0, {4'b0, 1'b0, big, tu, big | tu});
      idle($urandom_range(0, 2));
    end
    idle(3);
    compare_all("random");

    // Status FIFO stalled: second byte lost, overflow sticky
    reset_sync();
    compare_all("ps_sync");
    ps_tready = 1'b0;
    send_pkt(2, 1'b0, 0, 1'b0, 8'h00);
    send_pkt(2, 1'b1, 0, 1'b0, 8'h03);
    idle(2);
    void'(exp_ps.pop_back());
    check("psovf flag", 128'(ps_overflow), 128'd1);
    check("psovf held byte", {119'd0, ps_tvalid, ps_tdata}, {119'd0, 1'b1, 8'h00});
    exp_ovf = 1'b1;
    ps_tready = 1'b1;
    idle(3);
    compare_all("psovf");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
